delay_tap_calibrator: RTL and testbench



---
 rtl/delay_tap_calibrator_pkg.sv | 29 ++
 rtl/delay_tap_calibrator_vote_counter.sv | 31 +++
 rtl/delay_tap_calibrator.sv | 159 +++++++++++++++
 tb/tb_delay_tap_calibrator.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/delay_tap_calibrator_pkg.sv
// Shared types and sizing helpers for the delay-tap calibration controller.
package delay_tap_calibrator_pkg;

  localparam int unsigned DEF_TAPS          = 32;
  localparam int unsigned DEF_SEL_W         = 5;
  localparam int unsigned DEF_SETTLE_CYCLES = 8;
  localparam int unsigned DEF_SAMPLES       = 16;
  localparam int unsigned DEF_THRESH        = 9;

  typedef logic [DEF_SEL_W-1:0] tap_t;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    MEASURE,
    EVAL,
    DONE_OK,
    DONE_FAIL
  } state_t;

  // Counter width able to hold the value n itself (never zero width).
  function automatic int unsigned cnt_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

  localparam int unsigned DEF_SETTLE_W = cnt_w(DEF_SETTLE_CYCLES);
  localparam int unsigned DEF_SAMPLE_W = cnt_w(DEF_SAMPLES);

endpackage

// File: rtl/delay_tap_calibrator_vote_counter.sv
// Ones counter with threshold vote, reusable by any majority-vote training loop.
module tap_vote_counter
  import delay_tap_calibrator_pkg::*;
#(
  parameter int unsigned SAMPLES = DEF_SAMPLES,
  parameter int unsigned THRESH  = DEF_THRESH
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      clear,
  input  logic                      enable,
  input  logic                      sample,
  output logic [cnt_w(SAMPLES)-1:0] count,
  output logic                      vote_c
);

  localparam int unsigned CNT_W = cnt_w(SAMPLES);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && sample) begin
      count <= count + CNT_W'(1);
    end
  end

  assign vote_c = (count >= CNT_W'(THRESH));

endmodule

// File: rtl/delay_tap_calibrator.sv
// Sweeps the delay-buffer tap upward, majority-votes the phase detector per tap,
// and locks on the first 0->1 vote transition.
module delay_tap_calibrator
  import delay_tap_calibrator_pkg::*;
#(
  parameter int unsigned TAPS          = DEF_TAPS,
  parameter int unsigned SEL_W         = DEF_SEL_W,
  parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int unsigned SAMPLES       = DEF_SAMPLES,
  parameter int unsigned THRESH        = DEF_THRESH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             pd_sample,
  input  logic             override_en,
  input  logic [SEL_W-1:0] override_sel,
  output logic [SEL_W-1:0] tap_sel,
  output logic             busy,
  output logic             done,
  output logic             locked,
  output logic             error,
  output logic [SEL_W-1:0] lock_tap
);

  localparam int unsigned SETTLE_W = cnt_w(SETTLE_CYCLES);
  localparam int unsigned SAMPLE_W = cnt_w(SAMPLES);

  state_t              state, state_n;
  logic [SEL_W-1:0]    tap, tap_n, lock_tap_n;
  logic                busy_n, done_n, locked_n, error_n;
  logic                prev_vote, prev_vote_n, prev_valid, prev_valid_n;
  logic [SETTLE_W-1:0] settle_cnt, settle_cnt_n;
  logic [SAMPLE_W-1:0] meas_cnt, meas_cnt_n;
  logic                vote_clear, vote_en, vote;
  // The raw ones count is only of interest to other users of the counter.
  logic [SAMPLE_W-1:0] vote_count_unused;

  tap_vote_counter #(
    .SAMPLES (SAMPLES),
    .THRESH  (THRESH)
  ) u_vote (
    .clock  (clock),
    .reset  (reset),
    .clear  (vote_clear),
    .enable (vote_en),
    .sample (pd_sample),
    .count  (vote_count_unused),
    .vote_c (vote)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      tap        <= '0;
      lock_tap   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      locked     <= 1'b0;
      error      <= 1'b0;
      prev_vote  <= 1'b0;
      prev_valid <= 1'b0;
      settle_cnt <= '0;
      meas_cnt   <= '0;
    end else begin
      state      <= state_n;
      tap        <= tap_n;
      lock_tap   <= lock_tap_n;
      busy       <= busy_n;
      done       <= done_n;
      locked     <= locked_n;
      error      <= error_n;
      prev_vote  <= prev_vote_n;
      prev_valid <= prev_valid_n;
      settle_cnt <= settle_cnt_n;
      meas_cnt   <= meas_cnt_n;
    end
  end

  always_comb begin
    state_n      = state;
    tap_n        = tap;
    lock_tap_n   = lock_tap;
    busy_n       = busy;
    done_n       = 1'b0;
    locked_n     = locked;
    error_n      = error;
    prev_vote_n  = prev_vote;
    prev_valid_n = prev_valid;
    settle_cnt_n = settle_cnt;
    meas_cnt_n   = meas_cnt;
    vote_clear   = 1'b0;
    vote_en      = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          state_n      = SETTLE;
          tap_n        = '0;
          locked_n     = 1'b0;
          error_n      = 1'b0;
          prev_valid_n = 1'b0;
          busy_n       = 1'b1;
          settle_cnt_n = '0;
        end
      end
      SETTLE: begin
        vote_clear = 1'b1;
        if (settle_cnt == SETTLE_W'(SETTLE_CYCLES - 1)) begin
          state_n      = MEASURE;
          settle_cnt_n = '0;
          meas_cnt_n   = '0;
        end else begin
          settle_cnt_n = settle_cnt + SETTLE_W'(1);
        end
      end
      MEASURE: begin
        vote_en = 1'b1;
        if (meas_cnt == SAMPLE_W'(SAMPLES - 1)) begin
          state_n = EVAL;
        end else begin
          meas_cnt_n = meas_cnt + SAMPLE_W'(1);
        end
      end
      EVAL: begin
        // A 1 at the first tap has no preceding 0, so prev_valid gates the lock.
        if (prev_valid && !prev_vote && vote) begin
          lock_tap_n = tap;
          locked_n   = 1'b1;
          error_n    = 1'b0;
          done_n     = 1'b1;
          busy_n     = 1'b0;
          state_n    = DONE_OK;
        end else if (tap == SEL_W'(TAPS - 1)) begin
          locked_n = 1'b0;
          error_n  = 1'b1;
          done_n   = 1'b1;
          busy_n   = 1'b0;
          state_n  = DONE_FAIL;
        end else begin
          prev_vote_n  = vote;
          prev_valid_n = 1'b1;
          tap_n        = tap + SEL_W'(1);
          settle_cnt_n = '0;
          state_n      = SETTLE;
        end
      end
      DONE_OK, DONE_FAIL: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign tap_sel = override_en ? override_sel : (busy ? tap : lock_tap);

endmodule

// File: tb/tb_delay_tap_calibrator.sv
// Scoreboard bench for delay_tap_calibrator: directed pd_sample patterns per sweep.
module tb_delay_tap_calibrator;
  import delay_tap_calibrator_pkg::*;

  localparam int PER_TAP = 25;

  typedef struct {
    int   done_cyc;
    logic locked;
    logic error;
    tap_t lock_tap;
    tap_t tap_sel;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic       pd_sample = 1'b0;
  logic       override_en;
  logic [4:0] override_sel;
  logic [4:0] tap_sel;
  logic       busy, done, locked, error;
  logic [4:0] lock_tap;

  int   cyc = 0;
  int   compared = 0;
  int   mismatched = 0;
  int   s_start = 0;
  int   mode = 0;
  bit   run = 1'b0;
  exp_t sb[$];
  exp_t mon_e;

  delay_tap_calibrator dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .pd_sample    (pd_sample),
    .override_en  (override_en),
    .override_sel (override_sel),
    .tap_sel      (tap_sel),
    .busy         (busy),
    .done         (done),
    .locked       (locked),
    .error        (error),
    .lock_tap     (lock_tap)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // j = cycle index since the start edge: tap = j/25, phase 0..7 settle, 8..23 measure.
  function automatic logic pd_fn(input int m, input int j);
    int tap;
    int ph;
    int k;
    tap = j / PER_TAP;
    ph  = j % PER_TAP;
    k   = ph - 8;
    if (j < 0) return 1'b0;
    case (m)
      0: return (tap >= 13);
      1: return 1'b1;
      2: if (ph < 8) return 1'($urandom_range(0, 1));
         else return (tap >= 20);
      3: if (tap < 5) return 1'b0;
         else if (tap == 5) return (k >= 0 && k < 8);
         else if (tap == 6) return (k >= 0 && k < 9);
         else return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  always @(negedge clock) begin
    if (run) pd_sample = pd_fn(mode, cyc - s_start - 1);
    else     pd_sample = 1'b0;
  end

  // Monitor: every done pulse must match the oldest expected sweep result.
  always @(negedge clock) begin
    if (done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        check("done_cycle", cyc, mon_e.done_cyc);
        check("locked", int'(locked), int'(mon_e.locked));
        check("error", int'(error), int'(mon_e.error));
        check("lock_tap", int'(lock_tap), int'(mon_e.lock_tap));
        check("tap_sel_at_done", int'(tap_sel), int'(mon_e.tap_sel));
        check("busy_at_done", int'(busy), 0);
      end
    end
  end

  task automatic kick(input int m);
    @(negedge clock);
    mode    = m;
    s_start = cyc;
    run     = 1'b1;
    start   = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check("busy_after_start", int'(busy), 1);
  endtask

  task automatic run_sweep(input int m, input int ntaps, input logic l, input logic e,
                           input int lt, input int ts, input bit poke_done);
    int exp_cyc;
    kick(m);
    exp_cyc = s_start + 1 + PER_TAP * ntaps;
    sb.push_back('{done_cyc: exp_cyc, locked: l, error: e,
                   lock_tap: tap_t'(lt), tap_sel: tap_t'(ts)});
    if (poke_done) begin
      while (cyc < exp_cyc) @(negedge clock);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      check("start_at_done_ignored", int'(busy), 0);
    end
    while (cyc < exp_cyc + 2) begin
      @(negedge clock);
      if (override_en && (cyc % 100) == 0) check("override_tap_sel", int'(tap_sel), 31);
    end
    check("sweep_completed", sb.size(), 0);
    run = 1'b0;
  endtask

  initial begin
    reset        = 1'b1;
    start        = 1'b0;
    override_en  = 1'b0;
    override_sel = 5'd0;
    repeat (2) @(negedge clock);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_locked", int'(locked), 0);
    check("rst_error", int'(error), 0);
    check("rst_lock_tap", int'(lock_tap), 0);
    check("rst_tap_sel", int'(tap_sel), 0);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // Stuck-high detector: no 0->1 transition, fail after all 32 taps.
    run_sweep(1, 32, 1'b0, 1'b1, 0, 0, 1'b0);
    // Step at tap 13.
    run_sweep(0, 14, 1'b1, 1'b0, 13, 13, 1'b0);
    // Random settle-window noise must not influence the vote; step at 20.
    run_sweep(2, 21, 1'b1, 1'b0, 20, 20, 1'b0);
    // Threshold edge: 8 ones at tap 5, 9 at tap 6; start on the done cycle is dropped.
    run_sweep(3, 7, 1'b1, 1'b0, 6, 6, 1'b1);

    // Override forces tap_sel without changing the sweep outcome.
    override_sel = 5'd31;
    override_en  = 1'b1;
    run_sweep(0, 14, 1'b1, 1'b0, 13, 31, 1'b0);
    override_en = 1'b0;
    #1;
    check("tap_sel_after_override", int'(tap_sel), 13);

    // Reset mid-sweep at tap 10, then a clean restart.
    kick(0);
    while (cyc < s_start + 1 + 10 * PER_TAP + 5) @(negedge clock);
    reset = 1'b1;
    #1;
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(done), 0);
    check("midrst_locked", int'(locked), 0);
    check("midrst_error", int'(error), 0);
    check("midrst_lock_tap", int'(lock_tap), 0);
    check("midrst_tap_sel", int'(tap_sel), 0);
    run = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    run_sweep(0, 14, 1'b1, 1'b0, 13, 13, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
